vliw_bundle_issue: RTL and testbench
====================================

Name: vliw_bundle_issue

Overview:
- Decode-stage issue buffer directly upstream of the parallel integer execution lanes.
- Accepts fetched VLIW bundles of NLANES 32-bit instructions and buffers them in a small FIFO.
- Presents each bundle to the lanes' Decode inputs. When a bundle contains an intra-bundle register hazard, splits it across cycles so same-cycle lanes never depend on each other.

Parameters:
- XLEN, 64, address/PC width
- NLANES, 4, instruction slots per bundle (lane 0 = this core's base IEU)
- DEPTH, 4, bundle FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- BundleF  input  32*NLANES  fetched bundle; lane i at [32i+31:32i]
- BundlePCF  input  XLEN  PC of lane 0 of BundleF
- BundleValidF  input  1  BundleF valid
- BundleReadyF  output  1  FIFO can accept a bundle
- StallD  input  1  hold Decode registers
- FlushD  input  1  discard Decode contents and all buffered bundles
- InstrD  output  32*NLANES  per-lane instruction to each lane's InstrD
- PCD  output  XLEN*NLANES  per-lane PC
- LaneValidD  output  NLANES  per-lane instruction valid
- BundleSplitD  output  1  pulse: issued group is a partial bundle because of a hazard

Behaviour:
- Push occurs when BundleValidF && BundleReadyF. BundleReadyF = (count < DEPTH), registered. There is no same-cycle pop bypass: BundleReadyF stays 0 at full even if a pop occurs that cycle.
- The FIFO stores {BundleF, BundlePCF}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Head carries RemMask[NLANES-1:0]. It is set to all ones when an entry becomes head.
- Lane classification:
  - Lane writes rd: rd != 0 and opcode not in {0100011 store, 1100011 branch}.
  - Lane reads rs1: opcode not in {0110111, 0010111, 1101111}.
  - Lane reads rs2: opcode in {0110011, 0111011, 0100011, 1100011, 0101111}.
  - Lane j conflicts with earlier lane k if k writes rd and lane j reads rs1 or rs2 equal to that rd.
- Issue group: pending lanes (RemMask=1), starting at the lowest pending lane, up to but excluding the first pending lane that conflicts with an earlier lane in the group.
- FSM states:
  - EMPTY (count=0).
  - FRESH (head RemMask all ones).
  - PARTIAL (head RemMask not all ones).
- EMPTY, !StallD: D registers load InstrD = 0x00000013 (NOP) on all lanes, LaneValidD = 0.
- FRESH/PARTIAL, !StallD:
  - Group lanes load their instruction and LaneValidD=1.
  - Other lanes load NOP and LaneValidD=0.
  - Instructions keep their original lane slot.
  - PCD lane i = head PC + 4*i, modulo 2^XLEN, loaded for all lanes.
  - Group lanes are cleared from RemMask. If RemMask becomes 0, the entry pops (FRESH/PARTIAL -> next head or EMPTY); otherwise the state goes to PARTIAL.
  - BundleSplitD=1 for the cycle the registered group is partial (group smaller than the pending set when issued).
- StallD=1: D registers, RemMask and head hold; pushes still accepted.
- FlushD=1 (priority over StallD):
  - Next edge: all lanes NOP, LaneValidD=0, BundleSplitD=0.
  - count=0, pointers=0, RemMask reset.
  - A push in the same cycle is dropped.
- Latency: a bundle pushed at edge N into an empty FIFO appears on InstrD after edge N+1.
- Reset (any time, including mid-split):
  - InstrD all NOP, PCD=0, LaneValidD=0, BundleSplitD=0.
  - count=0, BundleReadyF=0 while reset=0, and 1 on the first edge after release.

Optional Feature:
- VLIW_WAW_SPLIT_EN defined: a lane also conflicts if it writes rd equal to the rd written by an earlier group lane (rd != 0), so there are no same-cycle duplicate writes.
- Undefined: only RAW conflicts split. Duplicate-rd writes issue together, and the regfile's highest-lane-wins rule resolves them.

Test Plan:
- Independent bundle {0x00100093, 0x00200113, 0x00300193, 0x00400213}, PC 0x80000000 -> one cycle LaneValidD=1111, PCD=0x80000000/04/08/0C, BundleSplitD=0, then EMPTY.
- Lane0 addi x1,x0,1 (0x00100093), lane2 add x5,x1,x1 (0x001082b3), lanes1/3 independent -> cycle1 LaneValidD=0011 with BundleSplitD=1, cycle2 LaneValidD=1100, then pop.
- Lane0 0x00000013 (rd=x0), lane1 add x6,x0,x0 -> no split, LaneValidD=1111.
- DEPTH=4, StallD=1, push 4 bundles -> BundleReadyF=0 after 4th; drop StallD -> bundles issue in order, BundleReadyF=1 the cycle after the first pop.
- FlushD during PARTIAL with 2 queued -> next cycle LaneValidD=0000, InstrD all 0x00000013, BundleReadyF=1, queued bundles never issue.
- reset=0 mid-split for 1 cycle -> outputs at reset values; after release BundleReadyF=1, and a new bundle issues whole.

Source files
------------

// File: rtl/vliw_bundle_issue_if.sv
// Fetch-to-decode bundle bus: fetch handshake in, per-lane decode registers out.
// master = fetch/decode environment, slave = the issue buffer.
interface vliw_bundle_issue_if #(
  parameter int XLEN   = 64,
  parameter int NLANES = 4
);
  logic [32*NLANES-1:0]   BundleF;
  logic [XLEN-1:0]        BundlePCF;
  logic                   BundleValidF;
  logic                   BundleReadyF;
  logic                   StallD;
  logic                   FlushD;
  logic [32*NLANES-1:0]   InstrD;
  logic [XLEN*NLANES-1:0] PCD;
  logic [NLANES-1:0]      LaneValidD;
  logic                   BundleSplitD;

  modport master (
    output BundleF, BundlePCF, BundleValidF, StallD, FlushD,
    input  BundleReadyF, InstrD, PCD, LaneValidD, BundleSplitD
  );

  modport slave (
    input  BundleF, BundlePCF, BundleValidF, StallD, FlushD,
    output BundleReadyF, InstrD, PCD, LaneValidD, BundleSplitD
  );
endinterface

// File: rtl/vliw_bundle_issue.sv
// VLIW bundle FIFO + hazard splitter feeding the lanes' Decode registers (VLIW_WAW_SPLIT_EN adds WAW splits).
// Latency: push to InstrD in 1 cycle; backpressure: BundleReadyF low at full, StallD holds D regs and head.
module vliw_bundle_issue #(
  parameter int XLEN   = 64,
  parameter int NLANES = 4,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               reset,
  vliw_bundle_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 32 * NLANES;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY, FRESH, PARTIAL} state_t;

  state_t                 state;
  logic [BW+XLEN-1:0]     mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_nxt;
  logic                   ready_q;
  logic [NLANES-1:0]      rem_mask, rem_nxt, grp;
  logic [BW-1:0]          head_bundle;
  logic [XLEN-1:0]        head_pc;
  logic                   push, issue, pop, split, stop, raw, waw;

  logic [4:0]             rd  [NLANES];
  logic [4:0]             rs1 [NLANES];
  logic [4:0]             rs2 [NLANES];
  logic [NLANES-1:0]      wr, r1, r2;
  logic [NLANES-1:0]      conf [NLANES];

  logic [BW-1:0]          issue_instr, instr_q;
  logic [XLEN*NLANES-1:0] issue_pc, pc_q;
  logic [NLANES-1:0]      vld_q;
  logic                   split_q;

  assign bus.BundleReadyF = ready_q;
  assign bus.InstrD       = instr_q;
  assign bus.PCD          = pc_q;
  assign bus.LaneValidD   = vld_q;
  assign bus.BundleSplitD = split_q;

  assign push = bus.BundleValidF && ready_q && !bus.FlushD;
  assign {head_bundle, head_pc} = mem[rd_ptr];
  assign issue = (state != EMPTY) && !bus.StallD && !bus.FlushD;

  for (genvar i = 0; i < NLANES; i++) begin : g_dec
    logic [6:0] opc;
    assign opc    = head_bundle[32*i +: 7];
    assign rd[i]  = head_bundle[32*i+7  +: 5];
    assign rs1[i] = head_bundle[32*i+15 +: 5];
    assign rs2[i] = head_bundle[32*i+20 +: 5];
    assign wr[i]  = (rd[i] != 5'd0) && (opc != 7'b0100011) && (opc != 7'b1100011);
    assign r1[i]  = (opc != 7'b0110111) && (opc != 7'b0010111) && (opc != 7'b1101111);
    assign r2[i]  = (opc == 7'b0110011) || (opc == 7'b0111011) || (opc == 7'b0100011) ||
                    (opc == 7'b1100011) || (opc == 7'b0101111);
  end

  // conf[j][k]: lane j may not share a cycle with earlier lane k
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int j = 0; j < NLANES; j++) begin
      conf[j] = '0;
      for (int k = 0; k < NLANES; k++) begin
        raw = wr[k] && ((r1[j] && (rs1[j] == rd[k])) || (r2[j] && (rs2[j] == rd[k])));
`ifdef VLIW_WAW_SPLIT_EN
        waw = wr[k] && wr[j] && (rd[j] == rd[k]);
`else
        waw = 1'b0;
`endif
        conf[j][k] = (k < j) && (raw || waw);
      end
    end
  end

  // Group grows over pending lanes until the first pending lane that hits a group member
  always_comb begin
    grp  = '0;
    stop = 1'b0;
    for (int j = 0; j < NLANES; j++) begin
      if (rem_mask[j] && !stop) begin
        if (|(conf[j] & grp)) stop = 1'b1;
        else                  grp[j] = 1'b1;
      end
    end
  end

  assign split     = (grp != rem_mask);
  assign rem_nxt   = rem_mask & ~grp;
  assign pop       = issue && (rem_nxt == '0);
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    issue_instr = '0;
    issue_pc    = '0;
    for (int i = 0; i < NLANES; i++) begin
      issue_instr[32*i +: 32]  = grp[i] ? head_bundle[32*i +: 32] : NOP;
      issue_pc[XLEN*i +: XLEN] = head_pc + XLEN'(4 * i);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.BundleF, bus.BundlePCF};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b0;
      rem_mask <= '1;
      instr_q  <= {NLANES{NOP}};
      pc_q     <= '0;
      vld_q    <= '0;
      split_q  <= 1'b0;
    end else if (bus.FlushD) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b1;
      rem_mask <= '1;
      instr_q  <= {NLANES{NOP}};
      vld_q    <= '0;
      split_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt < CW'(DEPTH));

      if (pop)        rem_mask <= '1;
      else if (issue) rem_mask <= rem_nxt;

      case (state)
        EMPTY:   if (push) state <= FRESH;
        default: begin
          if (pop)        state <= (count_nxt != '0) ? FRESH : EMPTY;
          else if (issue) state <= PARTIAL;
        end
      endcase

      if (!bus.StallD) begin
        if (issue) begin
          instr_q <= issue_instr;
          pc_q    <= issue_pc;
          vld_q   <= grp;
          split_q <= split;
        end else begin
          instr_q <= {NLANES{NOP}};
          vld_q   <= '0;
          split_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vliw_bundle_issue.sv
// Directed bench for vliw_bundle_issue; expected issue groups are queued when bundles are driven.
module tb_vliw_bundle_issue;
  localparam int XLEN = 64, NLANES = 4, DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vliw_bundle_issue_if #(.XLEN(XLEN), .NLANES(NLANES)) bus ();
  vliw_bundle_issue #(.XLEN(XLEN), .NLANES(NLANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] instr;
    logic [255:0] pc;
    logic [3:0]   vld;
    logic         split;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  localparam logic [127:0] BA = {32'h00400213, 32'h00300193, 32'h00200113, 32'h00100093};
  localparam logic [127:0] BS = {32'h00400213, 32'h001082b3, 32'h00200113, 32'h00100093};
  localparam logic [127:0] BZ = {32'h00000013, 32'h000003b3, 32'h00000333, 32'h00000013};
  localparam logic [127:0] BT = {32'h000083b7, 32'h00100093, 32'h00108133, 32'h005020a3};
  localparam logic [127:0] BW = {32'h00000013, 32'h00000013, 32'h00200193, 32'h00100193};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] b, input logic [63:0] pc,
                              input logic [3:0] m, input logic sp);
    exp_t e;
    for (int i = 0; i < NLANES; i++) begin
      e.instr[32*i +: 32] = m[i] ? b[32*i +: 32] : NOP;
      e.pc[64*i +: 64]    = pc + 64'(4 * i);
    end
    e.vld   = m;
    e.split = sp;
    return e;
  endfunction

  task automatic expect_grp(input logic [127:0] b, input logic [63:0] pc,
                            input logic [3:0] m, input logic sp);
    sb.push_back(mk(b, pc, m, sp));
  endtask

  task automatic drive(input logic [127:0] b, input logic [63:0] pc);
    bus.BundleF      = b;
    bus.BundlePCF    = pc;
    bus.BundleValidF = 1'b1;
  endtask

  // Every issued group must match the oldest queued expectation
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.LaneValidD !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 256'(bus.LaneValidD), 256'(0));
      end else begin
        e = sb.pop_front();
        chk("issue_instr", 256'(bus.InstrD), 256'(e.instr));
        chk("issue_pc", bus.PCD, e.pc);
        chk("issue_valid", 256'(bus.LaneValidD), 256'(e.vld));
        chk("issue_split", 256'(bus.BundleSplitD), 256'(e.split));
      end
    end
  endtask

  initial begin
    bus.BundleF      = '0;
    bus.BundlePCF    = '0;
    bus.BundleValidF = 1'b0;
    bus.StallD       = 1'b0;
    bus.FlushD       = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_instr", 256'(bus.InstrD), 256'({4{NOP}}));
    chk("rst_pc", bus.PCD, 256'(0));
    chk("rst_valid", 256'(bus.LaneValidD), 256'(0));
    chk("rst_split", 256'(bus.BundleSplitD), 256'(0));
    chk("rst_ready", 256'(bus.BundleReadyF), 256'(0));
    reset = 1'b1;
    tick();
    chk("ready_after_release", 256'(bus.BundleReadyF), 256'(1));

    // Independent bundle: whole issue one cycle after the push edge
    drive(BA, 64'h8000_0000);
    expect_grp(BA, 64'h8000_0000, 4'b1111, 1'b0);
    tick();
    chk("latency_not_early", 256'(bus.LaneValidD), 256'(0));
    bus.BundleValidF = 1'b0;
    tick();
    chk("indep_issued", 256'(sb.size()), 256'(0));
    tick();
    chk("indep_then_empty", 256'(bus.LaneValidD), 256'(0));

    // RAW hazard lane2 on lane0: split into 0011 then 1100
    drive(BS, 64'h1000);
    expect_grp(BS, 64'h1000, 4'b0011, 1'b1);
    expect_grp(BS, 64'h1000, 4'b1100, 1'b0);
    tick();
    bus.BundleValidF = 1'b0;
    tick();
    tick();
    tick();
    chk("split_done", 256'(sb.size()), 256'(0));
    chk("split_then_empty", 256'(bus.LaneValidD), 256'(0));

    // x0 writes, store rd field and lui rs1 field never create hazards
    drive(BZ, 64'h2000);
    expect_grp(BZ, 64'h2000, 4'b1111, 1'b0);
    tick();
    drive(BT, 64'h3000);
    expect_grp(BT, 64'h3000, 4'b1111, 1'b0);
    tick();
    // Duplicate-rd writes
    drive(BW, 64'h4000);
`ifdef VLIW_WAW_SPLIT_EN
    expect_grp(BW, 64'h4000, 4'b0001, 1'b1);
    expect_grp(BW, 64'h4000, 4'b1110, 1'b0);
`else
    expect_grp(BW, 64'h4000, 4'b1111, 1'b0);
`endif
    tick();
    bus.BundleValidF = 1'b0;
    tick();
    tick();
    tick();
    chk("nohaz_done", 256'(sb.size()), 256'(0));

    // Fill under stall, PC wrap on first bundle, extra push while full is dropped
    bus.StallD = 1'b1;
    drive(BA, 64'hFFFF_FFFF_FFFF_FFF8);
    expect_grp(BA, 64'hFFFF_FFFF_FFFF_FFF8, 4'b1111, 1'b0);
    tick();
    drive(BZ, 64'h5000);
    expect_grp(BZ, 64'h5000, 4'b1111, 1'b0);
    tick();
    drive(BT, 64'h6000);
    expect_grp(BT, 64'h6000, 4'b1111, 1'b0);
    tick();
    chk("ready_at_3", 256'(bus.BundleReadyF), 256'(1));
    drive(BA, 64'h7000);
    expect_grp(BA, 64'h7000, 4'b1111, 1'b0);
    tick();
    chk("ready_full", 256'(bus.BundleReadyF), 256'(0));
    drive(BZ, 64'h9000);
    tick();
    chk("stall_holds_valid", 256'(bus.LaneValidD), 256'(0));
    chk("ready_full_hold", 256'(bus.BundleReadyF), 256'(0));
    bus.BundleValidF = 1'b0;
    bus.StallD = 1'b0;
    tick();
    chk("ready_after_pop", 256'(bus.BundleReadyF), 256'(1));
    tick();
    tick();
    tick();
    tick();
    chk("fill_drained", 256'(sb.size()), 256'(0));
    chk("fill_then_empty", 256'(bus.LaneValidD), 256'(0));

    // Flush while PARTIAL with two bundles queued behind
    bus.StallD = 1'b1;
    drive(BS, 64'hA000);
    expect_grp(BS, 64'hA000, 4'b0011, 1'b1);
    tick();
    drive(BA, 64'hB000);
    tick();
    drive(BZ, 64'hC000);
    tick();
    bus.BundleValidF = 1'b0;
    bus.StallD = 1'b0;
    tick();
    chk("pre_flush_split", 256'(bus.BundleSplitD), 256'(1));
    bus.FlushD = 1'b1;
    bus.StallD = 1'b1;
    drive(BT, 64'hD000);
    tick();
    chk("flush_valid", 256'(bus.LaneValidD), 256'(0));
    chk("flush_instr", 256'(bus.InstrD), 256'({4{NOP}}));
    chk("flush_split", 256'(bus.BundleSplitD), 256'(0));
    chk("flush_ready", 256'(bus.BundleReadyF), 256'(1));
    bus.FlushD = 1'b0;
    bus.StallD = 1'b0;
    bus.BundleValidF = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("flush_nothing_left", 256'(bus.LaneValidD), 256'(0));

    // Reset in the middle of a split bundle
    drive(BS, 64'hD000);
    expect_grp(BS, 64'hD000, 4'b0011, 1'b1);
    tick();
    bus.BundleValidF = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_instr", 256'(bus.InstrD), 256'({4{NOP}}));
    chk("midrst_pc", bus.PCD, 256'(0));
    chk("midrst_valid", 256'(bus.LaneValidD), 256'(0));
    chk("midrst_split", 256'(bus.BundleSplitD), 256'(0));
    chk("midrst_ready", 256'(bus.BundleReadyF), 256'(0));
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_ready_release", 256'(bus.BundleReadyF), 256'(1));
    chk("midrst_no_remainder", 256'(bus.LaneValidD), 256'(0));
    drive(BA, 64'hE000);
    expect_grp(BA, 64'hE000, 4'b1111, 1'b0);
    tick();
    bus.BundleValidF = 1'b0;
    tick();
    tick();
    chk("post_rst_empty", 256'(bus.LaneValidD), 256'(0));

    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
